// File: rtl/shop_cmd_driver.sv
// shop_cmd_driver
//   Initiator side of the shop command interface. A host loads a queue of
//   right-justified ASCII tokens. After a start pulse the block waits for a
//   prompt (low char '?') on the shop response bus. It then presents the next
//   token on o_a with o_rdy held high for HOLD_CYCLES cycles. It waits for the
//   response bus to change, classifies that reply and counts error replies.
//
//   Optional feature macro: SHOP_DRV_TIMEOUT_EN
//     If defined, a reply that never arrives is abandoned after TIMEOUT_CYCLES
//     cycles and flagged on the sticky o_timeout. If undefined, the block waits
//     forever and o_timeout is tied to 0.
//
// Ports:
//   i_clk       clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_tok_wr    token queue write strobe (dropped while o_tok_full)
//   i_tok       token to enqueue
//   o_tok_full  queue full (registered)
//   i_start     start-script pulse (honoured only when idle)
//   i_resp      shop response bus
//   o_a         token to shop
//   o_rdy       token valid to shop
//   o_busy      script running
//   o_done      one-cycle pulse at script end
//   o_err_cnt   saturating count of error replies since last start
//   o_last_err  most recent error reply
//   o_timeout   sticky reply-timeout flag
module shop_cmd_driver #(
  parameter int unsigned TOK_NUM_ASCII_CHARS  = 7,
  parameter int unsigned RESP_NUM_ASCII_CHARS = 9,
  parameter int unsigned TOK_DEPTH            = 16,
  parameter int unsigned HOLD_CYCLES          = 2,
  parameter int unsigned TIMEOUT_CYCLES       = 64,
  parameter int unsigned ERR_CNT_BITS         = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_tok_wr,
  input  logic [TOK_NUM_ASCII_CHARS*8-1:0]  i_tok,
  output logic                              o_tok_full,
  input  logic                              i_start,
  input  logic [RESP_NUM_ASCII_CHARS*8-1:0] i_resp,
  output logic [TOK_NUM_ASCII_CHARS*8-1:0]  o_a,
  output logic                              o_rdy,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [ERR_CNT_BITS-1:0]           o_err_cnt,
  output logic [RESP_NUM_ASCII_CHARS*8-1:0] o_last_err,
  output logic                              o_timeout
);

  localparam int unsigned TokW  = TOK_NUM_ASCII_CHARS * 8;
  localparam int unsigned RespW = RESP_NUM_ASCII_CHARS * 8;
  localparam int unsigned AddrW = (TOK_DEPTH > 1) ? $clog2(TOK_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(TOK_DEPTH + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPrompt,
    StDrive,
    StWaitResp,
    StDone
  } state_e;

  // Error replies, zero-padded on the left as they appear on the bus.
  function automatic logic is_err(input logic [RespW-1:0] r);
    return (r == RespW'("InvalCmd"))  || (r == RespW'("InvalPerm")) ||
           (r == RespW'("UsrUnknwn")) || (r == RespW'("UsrTaken"))  ||
           (r == RespW'("NoDelAdmn")) || (r == RespW'("ItmsFull"))  ||
           (r == RespW'("ItmExists")) || (r == RespW'("ItmUnknwn")) ||
           (r == RespW'("NtYourItm")) || (r == RespW'("NoStock"));
  endfunction

  // Token queue
  logic [TokW-1:0]  mem_q [TOK_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             push, pop, empty;

  assign push  = i_tok_wr & ~full_q;
  assign empty = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    full_d = (cnt_d == CntW'(TOK_DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_tok;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Control FSM
  state_e            state_q, state_d;
  logic [TokW-1:0]   a_q, a_d;
  logic [RespW-1:0]  snap_q, snap_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [ERR_CNT_BITS-1:0] err_q, err_d;
  logic [RespW-1:0]  last_err_q, last_err_d;
  logic              done_q, done_d;
  logic              reply;
`ifdef SHOP_DRV_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic              timed_out;
  assign timed_out = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
`endif

  // The shop answers by changing the bus; an identical answer is invisible.
  assign reply = (i_resp != snap_q);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    snap_d     = snap_q;
    hold_d     = hold_q;
    err_d      = err_q;
    last_err_d = last_err_q;
    done_d     = 1'b0;
    pop        = 1'b0;
`ifdef SHOP_DRV_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (i_start) begin
          if (!empty) begin
            err_d      = '0;
            last_err_d = '0;
`ifdef SHOP_DRV_TIMEOUT_EN
            timeout_d  = 1'b0;
`endif
            state_d    = StWaitPrompt;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StWaitPrompt: begin
        if (empty) begin
          state_d = StDone;
        end else if (i_resp[7:0] == 8'h3F) begin
          pop     = 1'b1;
          a_d     = mem_q[rd_ptr_q];
          snap_d  = i_resp;
          hold_d  = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          state_d = StWaitResp;
`ifdef SHOP_DRV_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StWaitResp: begin
`ifdef SHOP_DRV_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 1'b1;
`endif
        if (reply) begin
          if (is_err(i_resp)) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            last_err_d = i_resp;
          end
          state_d = empty ? StDone : StWaitPrompt;
        end
`ifdef SHOP_DRV_TIMEOUT_EN
        else if (timed_out) begin
          timeout_d = 1'b1;
          state_d   = empty ? StDone : StWaitPrompt;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      snap_q     <= '0;
      hold_q     <= '0;
      err_q      <= '0;
      last_err_q <= '0;
      done_q     <= 1'b0;
`ifdef SHOP_DRV_TIMEOUT_EN
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      snap_q     <= snap_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
      done_q     <= done_d;
`ifdef SHOP_DRV_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once.
  assign o_tok_full = full_q;
  assign o_a        = a_q;
  assign o_rdy      = (state_q == StDrive);
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone) | done_q;
  assign o_err_cnt  = err_q;
  assign o_last_err = last_err_q;
`ifdef SHOP_DRV_TIMEOUT_EN
  assign o_timeout  = timeout_q;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: doc/shop_cmd_driver.md
Name: shop_cmd_driver

Overview:
Initiator/terminal side of the shop command interface. It holds a host-loaded queue of ASCII tokens (commands, usernames, item names, stock values) and waits for a prompt on the shop's response bus. For each prompt it presents the next token with a ready pulse, then classifies the shop's reply and counts error replies. Used as the scripted stimulus front-end and as the on-chip console driver for the shop database block.

Parameters:
TOK_NUM_ASCII_CHARS  7   token width in chars; must match shop command-input width
RESP_NUM_ASCII_CHARS 9   response width in chars; must match shop response-output width
TOK_DEPTH            16  token queue entries; power of 2
HOLD_CYCLES          2   cycles o_rdy is held high per token, >=1
TIMEOUT_CYCLES       64  reply wait limit, used only with SHOP_DRV_TIMEOUT_EN
ERR_CNT_BITS         8   error counter width

Ports:
i_clk       in   1                       clock, all logic on rising edge
i_reset_n   in   1                       asynchronous, active-low reset
i_tok_wr    in   1                       token queue write strobe
i_tok       in   TOK_NUM_ASCII_CHARS*8   token, right-justified ASCII
o_tok_full  out  1                       queue full
i_start     in   1                       start-script pulse
i_resp      in   RESP_NUM_ASCII_CHARS*8  shop response bus, right-justified ASCII
o_a         out  TOK_NUM_ASCII_CHARS*8   token to shop
o_rdy       out  1                       token valid to shop
o_busy      out  1                       script running
o_done      out  1                       one-cycle pulse at script end
o_err_cnt   out  ERR_CNT_BITS            error replies since last start
o_last_err  out  RESP_NUM_ASCII_CHARS*8  most recent error reply
o_timeout   out  1                       sticky, reply timeout occurred

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0. Queue is emptied. FSM goes to IDLE. A reset mid-script drops o_rdy in the same instant it is asserted.
- Queue: a write is accepted when i_tok_wr & !o_tok_full, in any state. A write while full is dropped silently. Pointers wrap modulo TOK_DEPTH. o_tok_full is registered and asserts on the cycle after the write that fills the queue.
- Prompt: i_resp[7:0] == 8'h3F ('?').
- Error reply: i_resp equals any of InvalCmd, InvalPerm, UsrUnknwn, UsrTaken, NoDelAdmn, ItmsFull, ItmExists, ItmUnknwn, NtYourItm, NoStock. Comparison is on the full width after right-justified zero-padding.
- FSM states: IDLE, WAIT_PROMPT, DRIVE, WAIT_RESP, DONE.
- IDLE: o_busy=0.
  - i_start with queue non-empty: clear o_err_cnt, o_last_err and o_timeout, then go to WAIT_PROMPT.
  - i_start with queue empty: o_done pulses on the next cycle and the FSM stays in IDLE.
- i_start outside IDLE is ignored.
- WAIT_PROMPT: on a prompt, pop the queue head into o_a, snapshot i_resp, then go to DRIVE.
- DRIVE: o_rdy=1 for exactly HOLD_CYCLES cycles, then o_rdy=0 and the FSM goes to WAIT_RESP. o_a holds the token until the next pop.
- WAIT_RESP: a reply is i_resp != snapshot.
  - On a reply: if it is an error, o_err_cnt increments (saturating at all-ones) and o_last_err takes i_resp.
  - Next state after a reply: DONE if the queue is empty, else WAIT_PROMPT.
  - A reply that is itself a prompt is accepted in WAIT_PROMPT on the following cycle.
- DONE: o_done=1 for one cycle, then IDLE. o_busy=1 in all states except IDLE.
- A reply identical to the snapshot cannot be detected. The bench/shop must change i_resp, or the timeout must be enabled.
- A token written during a run is consumed by that run if it is present when the queue-empty check is made.

Optional Feature:
SHOP_DRV_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_RESP and increments each cycle in that state.
  - Reaching TIMEOUT_CYCLES sets o_timeout (sticky until the next accepted start or reset).
  - The FSM then proceeds exactly as on a non-error reply.
- Undefined: no counter; WAIT_RESP waits indefinitely; o_timeout is tied to 0.

Test Plan:
- Load "Login","Adm"; i_start; i_resp="Cmd?" -> o_a="Login", o_rdy high 2 cycles. i_resp="Usrname?" -> o_a="Adm". i_resp="Cmd?" -> o_done pulse, o_err_cnt=0.
- Load "Foo"; i_resp="Cmd?"; start; after o_rdy set i_resp="InvalCmd" -> o_err_cnt=1, o_last_err="InvalCmd", o_done pulse.
- Write 17 tokens to an empty queue -> o_tok_full=1 after the 16th. Run the script -> exactly 16 o_rdy pulses.
- With macro: drive one token, hold i_resp constant for 64 cycles -> o_timeout=1, o_err_cnt=0, o_done pulse. Without macro: o_busy stays 1 for 200 cycles.
- Assert i_reset_n=0 during DRIVE -> o_rdy=0 immediately, all outputs 0. After release, i_start -> o_done pulse (queue empty).
- i_start with empty queue -> o_done 1 cycle later, o_busy never 1. A second i_start during an active run -> ignored, o_err_cnt not cleared.
